sdram_timing_checker: RTL



---
 rtl/sdram_timing_checker.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_timing_checker.sv
// SDRAM command-bus timing monitor: tracks per-bank open state and distance
// counters, and reports the highest-priority (lowest-code) violation per command.

// Per-bank state: open flag plus saturating distance counters since ACT/PRE/WR.
module sdram_bank_tracker #(
    parameter int pCntW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             act,
    input  logic             pre,
    input  logic             wr,
    output logic             open,
    output logic [pCntW-1:0] since_act,
    output logic [pCntW-1:0] since_pre,
    output logic [pCntW-1:0] since_wr
);
    localparam logic [pCntW-1:0] CMAX = '1;
    localparam logic [pCntW-1:0] ONE  = pCntW'(1);

    function automatic logic [pCntW-1:0] bump(input logic [pCntW-1:0] c);
        return (c == CMAX) ? c : c + ONE;
    endfunction

    // Counters restart at 1 the cycle after their event; reset saturates them so
    // nothing after reset looks too close to a prior event.
    always_ff @(posedge clk) begin
        if (reset) begin
            open      <= 1'b0;
            since_act <= CMAX;
            since_pre <= CMAX;
            since_wr  <= CMAX;
        end else begin
            open      <= act ? 1'b1 : (pre ? 1'b0 : open);
            since_act <= act ? ONE : bump(since_act);
            since_pre <= pre ? ONE : bump(since_pre);
            since_wr  <= wr  ? ONE : bump(since_wr);
        end
    end
endmodule

module sdram_timing_checker #(
    parameter int pTrcd = 3,
    parameter int pTrp  = 3,
    parameter int pTras = 6,
    parameter int pTrrd = 2,
    parameter int pTwr  = 2,
    parameter int pTrfc = 8,
    parameter int pCntW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ba,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic        a10,
    output logic [3:0]  bank_open,
    output logic        err,
    output logic [3:0]  err_code,
    output logic [1:0]  err_bank,
    output logic [15:0] err_cnt
);
    localparam int NB = 4;
    localparam logic [pCntW-1:0] CMAX = '1;
    localparam logic [pCntW-1:0] ONE  = pCntW'(1);
    localparam logic [pCntW-1:0] TRCD = pCntW'(pTrcd);
    localparam logic [pCntW-1:0] TRP  = pCntW'(pTrp);
    localparam logic [pCntW-1:0] TRAS = pCntW'(pTras);
    localparam logic [pCntW-1:0] TRRD = pCntW'(pTrrd);
    localparam logic [pCntW-1:0] TWR  = pCntW'(pTwr);
    localparam logic [pCntW-1:0] TRFC = pCntW'(pTrfc);

    typedef enum logic [3:0] {
        C_NONE, C_NOP, C_ACT, C_RD, C_WR, C_BT, C_PRE, C_PREA, C_AREF, C_LMR, C_BAD
    } cmd_t;

    cmd_t cmd;

    logic [NB-1:0]            act_b, pre_b, wr_b;
    logic [NB-1:0][pCntW-1:0] since_act, since_pre, since_wr;
    logic [pCntW-1:0]         since_act_any, since_aref;

    logic       viol;
    logic [3:0] v_code;
    logic [1:0] v_bank;
    logic       f6, f7, any_open, rfc_early;
    logic [1:0] b6, b7, bo;

    function automatic logic [pCntW-1:0] bump(input logic [pCntW-1:0] c);
        return (c == CMAX) ? c : c + ONE;
    endfunction

    // Decode the raw pins; unknown strobes under chip select become C_BAD.
    always_comb begin
        cmd = C_NONE;
        if (cs_n == 1'b0) begin
            if ($isunknown({ras_n, cas_n, we_n})) cmd = C_BAD;
            else begin
                case ({ras_n, cas_n, we_n})
                    3'b111:  cmd = C_NOP;
                    3'b011:  cmd = C_ACT;
                    3'b101:  cmd = C_RD;
                    3'b100:  cmd = C_WR;
                    3'b110:  cmd = C_BT;
                    3'b010:  cmd = a10 ? C_PREA : C_PRE;
                    3'b001:  cmd = C_AREF;
                    3'b000:  cmd = C_LMR;
                    default: cmd = C_NOP;
                endcase
            end
        end
    end

    // Per-bank event strobes; PREA counts as a precharge of every bank.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            act_b[i] = (cmd == C_ACT) && (ba == 2'(i));
            pre_b[i] = ((cmd == C_PRE) && (ba == 2'(i))) || (cmd == C_PREA);
            wr_b[i]  = (cmd == C_WR) && (ba == 2'(i));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NB; g++) begin : g_bank
            sdram_bank_tracker #(.pCntW(pCntW)) u_bank (
                .clk       (clk),
                .reset     (reset),
                .act       (act_b[g]),
                .pre       (pre_b[g]),
                .wr        (wr_b[g]),
                .open      (bank_open[g]),
                .since_act (since_act[g]),
                .since_pre (since_pre[g]),
                .since_wr  (since_wr[g])
            );
        end
    endgenerate

    // Bank-independent distance counters (any ACT, AREF).
    always_ff @(posedge clk) begin
        if (reset) begin
            since_act_any <= CMAX;
            since_aref    <= CMAX;
        end else begin
            since_act_any <= (cmd == C_ACT)  ? ONE : bump(since_act_any);
            since_aref    <= (cmd == C_AREF) ? ONE : bump(since_aref);
        end
    end

    // Evaluate checks for the sampled command; if-else order encodes code priority.
    always_comb begin
        viol = 1'b0; v_code = 4'd0; v_bank = 2'd0;
        f6 = 1'b0; f7 = 1'b0; b6 = 2'd0; b7 = 2'd0; bo = 2'd0;
        any_open  = |bank_open;
        rfc_early = since_aref < TRFC;
        // Lowest open bank failing each precharge check, and lowest open bank.
        for (int i = NB - 1; i >= 0; i--) begin
            if (bank_open[i] && since_act[i] < TRAS) begin f6 = 1'b1; b6 = 2'(i); end
            if (bank_open[i] && since_wr[i] < TWR)   begin f7 = 1'b1; b7 = 2'(i); end
            if (bank_open[i]) bo = 2'(i);
        end
        case (cmd)
            C_ACT: begin
                viol = 1'b1; v_bank = ba;
                if (bank_open[ba])                 v_code = 4'd1;
                else if (since_pre[ba] < TRP)      v_code = 4'd2;
                else if (since_act_any < TRRD)     v_code = 4'd3;
                else if (rfc_early)                v_code = 4'd9;
                else                               viol = 1'b0;
            end
            C_RD, C_WR: begin
                viol = 1'b1; v_bank = ba;
                if (!bank_open[ba])                v_code = 4'd4;
                else if (since_act[ba] < TRCD)     v_code = 4'd5;
                else if (rfc_early)                v_code = 4'd9;
                else                               viol = 1'b0;
            end
            C_PRE: begin
                viol = 1'b1; v_bank = ba;
                if (bank_open[ba] && since_act[ba] < TRAS)     v_code = 4'd6;
                else if (bank_open[ba] && since_wr[ba] < TWR)  v_code = 4'd7;
                else if (rfc_early)                            v_code = 4'd9;
                else                                           viol = 1'b0;
            end
            C_PREA: begin
                viol = 1'b1;
                if (f6)             begin v_code = 4'd6; v_bank = b6; end
                else if (f7)        begin v_code = 4'd7; v_bank = b7; end
                else if (rfc_early) v_code = 4'd9;
                else                viol = 1'b0;
            end
            C_AREF, C_LMR: begin
                viol = 1'b1;
                if (any_open)       begin v_code = 4'd8; v_bank = bo; end
                else if (rfc_early) v_code = 4'd9;
                else                viol = 1'b0;
            end
            C_BAD: begin
                viol = 1'b1; v_code = 4'd15;
            end
            default: ;
        endcase
    end

    // Registered error report; code/bank hold between violations.
    always_ff @(posedge clk) begin
        if (reset) begin
            err      <= 1'b0;
            err_code <= 4'd0;
            err_bank <= 2'd0;
            err_cnt  <= 16'd0;
        end else begin
            err <= viol;
            if (viol) begin
                err_code <= v_code;
                err_bank <= v_bank;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    a_cmd_known: assert property (@(posedge clk) disable iff (reset) cmd != C_BAD);
endmodule
